mem_arbiter: RTL and testbench

- Arbitrates one shared single-port memory between the instruction-fetch port (IF) and the data port (MEM stage) of the 5-stage MIPS pipeline.
- Sequences each granted access over MEM_LAT wait cycles and returns registered read data with a one-cycle ready pulse.
- Drives the stall outputs that the hazard logic ORs into PCWrite, IF_IDWrite and the pipeline-freeze enables.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_lat_cnt.sv | 28 ++
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_I,
        GNT_D
    } grant_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_lat_cnt.sv
// rtl/mem_arb_lat_cnt.sv - loadable down-counter timing the ACCESS wait
// tc is high while the count sits at zero, i.e. in the final access cycle.
module mem_arb_lat_cnt
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - IF/MEM single-port memory arbiter with stall outputs
// Optional MEM_ARB_RR_EN: round-robin between simultaneous requests instead of data priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              d_stall
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

    state_t state, state_next;
    grant_t grant, grant_next;

    logic pick_d;
    logic pick_i;
    logic start;
    logic access_end;
    logic cnt_load;
    logic cnt_en;
    logic cnt_tc;

`ifdef MEM_ARB_RR_EN
    grant_t last_grant;

    // Data wins a tie unless it was also the last port served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= GNT_I;
        end else if (start) begin
            last_grant <= pick_d ? GNT_D : GNT_I;
        end
    end

    assign pick_d = d_req & (~if_req | (last_grant == GNT_I));
`else
    assign pick_d = d_req;
`endif

    assign pick_i     = if_req & ~pick_d;
    assign start      = (state == IDLE) & (pick_d | pick_i);
    assign access_end = (state == ACCESS) & cnt_tc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= GNT_NONE;
        end else begin
            state <= state_next;
            grant <= grant_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant;
        cnt_load   = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_d) begin
                    grant_next = GNT_D;
                    state_next = ACCESS;
                    cnt_load   = 1'b1;
                end else if (pick_i) begin
                    grant_next = GNT_I;
                    state_next = ACCESS;
                    cnt_load   = 1'b1;
                end
            end
            ACCESS: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Requests still high here are the ones just answered.
                state_next = IDLE;
                grant_next = GNT_NONE;
            end
            default: begin
                state_next = IDLE;
                grant_next = GNT_NONE;
            end
        endcase
    end

    mem_arb_lat_cnt u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .en       (cnt_en),
        .tc       (cnt_tc)
    );

    // The memory bus registers double as the request latch for the whole access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_ready <= 1'b0;
            d_ready  <= 1'b0;
            if (start) begin
                mem_en <= 1'b1;
                if (pick_d) begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                end
            end
            if (access_end) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
                if (grant == GNT_I) begin
                    if_rdata <= mem_rdata;
                    if_ready <= 1'b1;
                end else if (grant == GNT_D) begin
                    d_ready <= 1'b1;
                    if (!mem_we) begin
                        d_rdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign if_stall = if_req & ~if_ready;
    assign d_stall  = d_req & ~d_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, d_ready, mem_en, mem_we, if_stall, d_stall;

    logic        if_req1;
    logic [31:0] if_addr1;
    logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        if_ready1, d_ready1, mem_en1, mem_we1, if_stall1, d_stall1;

    logic        tb_init;
    logic [31:0] phys    [64];
    logic [31:0] ref_mem [64];
    bit          m_last_d;
    logic [31:0] m_d_rdata;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .if_stall(if_stall), .d_stall(d_stall)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(d_rdata1), .d_ready(d_ready1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .if_stall(if_stall1), .d_stall(d_stall1)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 16) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0001_0011;
    endfunction

    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 64; i++) phys[i] <= init_word(i);
        end else if (mem_en && mem_we) begin
            phys[mem_addr[7:2]] <= mem_wdata;
        end
    end

    assign mem_rdata  = phys[mem_addr[7:2]];
    assign mem_rdata1 = 32'hC0DE_0000 | mem_addr1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called in cycle 0 (just after a rising edge); returns in the first free IDLE cycle.
    task automatic run_txn(input bit use_i, input bit use_d, input bit we,
                           input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd);
        int          t_i, t_d, t_last;
        bit          d_first, two, i_pend, d_pend, e_en, first_win;
        logic [31:0] exp_i, exp_d;

        two = use_i && use_d;
`ifdef MEM_ARB_RR_EN
        d_first = use_d && !(use_i && m_last_d);
`else
        d_first = use_d;
`endif
        t_i = -1;
        t_d = -1;
        if (d_first) begin
            t_d = LAT + 1;
            if (use_i) t_i = 2 * LAT + 3;
        end else begin
            t_i = LAT + 1;
            if (use_d) t_d = 2 * LAT + 3;
        end
        t_last = two ? 2 * LAT + 3 : LAT + 1;

        exp_i = 32'h0;
        exp_d = m_d_rdata;
        for (int p = 0; p < 2; p++) begin
            if ((p == 0) == d_first) begin
                if (use_d) begin
                    if (we) ref_mem[da[7:2]] = wd;
                    else    exp_d = ref_mem[da[7:2]];
                    m_last_d = 1'b1;
                end
            end else if (use_i) begin
                exp_i    = ref_mem[ia[7:2]];
                m_last_d = 1'b0;
            end
        end
        m_d_rdata = exp_d;

        i_pend  = use_i;
        d_pend  = use_d;
        if_addr = ia;
        d_addr  = da;
        d_we    = we;
        d_wdata = wd;
        for (int k = 0; k <= t_last + 3; k++) begin
            if_req = i_pend;
            d_req  = d_pend;
            if (k > t_last && !i_pend && !d_pend) break;
            @(negedge clk);
            first_win = (k >= 1 && k <= LAT);
            e_en = first_win || (two && k >= LAT + 3 && k <= 2 * LAT + 2);
            chk("if_ready", if_ready, k == t_i);
            chk("d_ready", d_ready, k == t_d);
            chk("if_stall", if_stall, if_req && k != t_i);
            chk("d_stall", d_stall, d_req && k != t_d);
            chk("mem_en", mem_en, e_en);
            if (e_en) begin
                if (first_win == d_first) begin
                    chk("mem_addr_d", mem_addr, da);
                    chk("mem_we_d", mem_we, we);
                    if (we) chk("mem_wdata", mem_wdata, wd);
                end else begin
                    chk("mem_addr_i", mem_addr, ia);
                    chk("mem_we_i", mem_we, 0);
                end
            end
            if (k == t_i) chk("if_rdata", if_rdata, exp_i);
            if (k == t_d) chk("d_rdata", d_rdata, exp_d);
            if (if_ready) i_pend = 1'b0;
            if (d_ready)  d_pend = 1'b0;
            @(posedge clk);
            #1;
        end
        if (i_pend || d_pend) begin
            chk("ready_timeout", {30'h0, i_pend, d_pend}, 0);
            if_req = 1'b0;
            d_req  = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        tb_init  = 1'b1;
        if_req   = 1'b0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        if_addr  = 32'h0;
        d_addr   = 32'h0;
        d_wdata  = 32'h0;
        if_req1  = 1'b0;
        if_addr1 = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        m_last_d  = 1'b0;
        m_d_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        tb_init = 1'b0;

        @(negedge clk);
        chk("rst_if_ready", if_ready, 0);
        chk("rst_d_ready", d_ready, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_stalls", {if_stall, d_stall}, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // MEM_LAT=1 instance: back-to-back fetches, stale request in DONE ignored.
        if_req1  = 1'b1;
        if_addr1 = 32'h0;
        for (int k = 0; k <= 7; k++) begin
            if (k == 3) if_addr1 = 32'h4;
            if (k == 6) if_req1 = 1'b0;
            @(negedge clk);
            chk("l1_if_ready", if_ready1, k == 2 || k == 5);
            chk("l1_mem_en", mem_en1, k == 1 || k == 4);
            chk("l1_if_stall", if_stall1, if_req1 && !(k == 2 || k == 5));
            chk("l1_d_ready", {d_ready1, d_stall1, mem_we1}, 0);
            if (k == 4) chk("l1_mem_addr", mem_addr1, 32'h4);
            if (k == 2) chk("l1_rdata0", if_rdata1, 32'hC0DE_0000);
            if (k == 5) chk("l1_rdata4", if_rdata1, 32'hC0DE_0004);
            @(posedge clk);
            #1;
        end
        chk("l1_d_rdata", d_rdata1, 0);
        chk("l1_mem_wdata", mem_wdata1, 0);

        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0);
        chk("load_deadbeef", m_d_rdata, 32'hDEADBEEF);
        run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h80, 32'h12345678);
        run_txn(1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0);
        run_txn(1'b1, 1'b1, 1'b1, 32'h80, 32'h84, 32'h5555AAAA);

        // Reset in the first ACCESS cycle of a store abandons it.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h80;
        d_wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        chk("rst_mid_en_pre", {mem_en, mem_we}, 2'b11);
        reset = 1'b1;
        #1;
        chk("rst_mid_en", mem_en, 0);
        chk("rst_mid_we", mem_we, 0);
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b0;
        m_last_d  = 1'b0;
        m_d_rdata = 32'h0;
        @(negedge clk);
        chk("rst_mid_ready", {if_ready, d_ready}, 0);
        chk("rst_mid_d_rdata", d_rdata, 0);
        @(posedge clk);
        #1;
        run_txn(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h80, 32'h0);

        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] ia, da;
            kind = int'($urandom_range(0, 3));
            ia   = 32'($urandom_range(0, 63)) << 2;
            da   = 32'($urandom_range(0, 63)) << 2;
            run_txn(kind != 1, kind != 0, 1'($urandom_range(0, 1)), ia, da, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
